adex_core_scheduler: RTL
========================

// Module: adex_core_scheduler
// PURPOSE
//  Time-multiplexes one AdEx compute core across N_NEURONS neuron state slots. Each timestep tick
//  starts a sweep. For every slot the block issues that slot's V/w to the core, waits for done, and
//  writes the result back. Spike results are queued as neuron-index events behind a valid/ready port.
//  Sits between the parameter loader / TT pin wrapper and the 16-bit Q8.8 neuron datapath.
// PARAMETERS
//  N_NEURONS   4      neuron slots; power of 2, range 2..16
//  STATE_W     16     width of V and w (signed Q8.8)
//  FIFO_DEPTH  4      spike-event queue depth; power of 2
//  TIMEOUT     63     max cycles in WAIT before core_done is declared missing
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  enable       in   1        permits new sweeps
//  tick         in   1        timestep strobe, 1-cycle pulse
//  core_start   out  1        1-cycle pulse: core latches core_v_in/core_w_in
//  core_idx     out  log2N    slot index being computed
//  core_v_in    out  STATE_W  V of current slot
//  core_w_in    out  STATE_W  w of current slot
//  core_done    in   1        1-cycle pulse: core outputs valid
//  core_v_out   in   STATE_W  updated V
//  core_w_out   in   STATE_W  updated w
//  core_spike   in   1        spike flag, qualified by core_done
//  ev_valid     out  1        spike event available
//  ev_idx       out  log2N    index of spiking neuron
//  ev_ready     in   1        consumer accepts event
//  busy         out  1        high whenever the FSM is not in S_IDLE
//  sweep_done   out  1        1-cycle pulse after the last slot is written back
//  err_flags    out  3        sticky: [0] tick overrun, [1] event dropped, [2] core timeout
// BEHAVIOUR
//  Reset: all V slots = V_INIT (-65<<<8 = 16'hBF00); all w slots = 0. FSM=S_IDLE, idx=0. FIFO empty.
//   All outputs 0 except core_v_in/core_w_in, which show slot 0.
//  FSM states:
//   S_IDLE: if tick && enable -> idx=0, go to S_ISSUE.
//   S_ISSUE: core_start=1 for exactly 1 cycle; timeout counter cleared; go to S_WAIT.
//   S_WAIT: on core_done -> latch core_v_out, core_w_out, core_spike; go to S_WB.
//    If the counter reaches TIMEOUT -> set err[2], leave the slot unchanged, go to S_WB with no write.
//   S_WB: write V/w into slot idx. If spike, push idx into the FIFO.
//    If idx==N-1 or !enable -> pulse sweep_done (only when idx==N-1), go to S_IDLE.
//    Otherwise idx++ and go to S_ISSUE.
//  Latency per slot: 3 cycles + core latency. Sweep length: N*(3+Lcore) cycles.
//  core_v_in/core_w_in come combinationally from slot[core_idx]; they are stable from S_ISSUE
//   until the write in S_WB.
//  tick while busy: the tick is ignored (no queuing); set err[0].
//  tick in the same cycle as the final S_WB: ignored; err[0] set.
//  enable dropped mid-sweep: the current slot completes through S_WB, then S_IDLE.
//   The next sweep restarts at idx 0.
//  core_done outside S_WAIT: ignored.
//  FIFO handshake: an event transfers when ev_valid && ev_ready. ev_idx is the head; order is FIFO.
//  FIFO full: a push is dropped and err[1] is set, unless a pop happens in the same cycle, in which
//   case the push is accepted.
//  FIFO empty: a simultaneous push and pop is legal; the event appears on ev_valid the next cycle
//   (no fall-through).
//  err_flags: cleared only by reset.
//  Mid-operation reset: reset wins in every state; the FIFO is flushed and slot state reinitialised.
//  No arithmetic is done here. V/w are stored verbatim; saturation belongs to the core.
// STRUCTURE
//  Shared package adex_pkg: V_INIT_Q88, W_INIT_Q88, Q_FRAC=8, sched state enum
//   (S_IDLE/S_ISSUE/S_WAIT/S_WB).
//  One sub-module: spike_event_fifo (FIFO_DEPTH x log2N, valid/ready, full/empty, registered output).
//  Slot storage is a flop array of N x 2 x STATE_W. The idx counter wraps via the explicit N-1 compare.
// TESTING
//  1 Reset, then tick with an echo core model (core_done 2 cycles after start, V_out=V_in+256,
//    no spike) -> 4 core_start pulses with idx 0..3 and core_v_in=16'hBF00.
//    sweep_done fires once; slot V becomes 16'hC000.
//  2 Core spikes on idx 1 and 3, ev_ready=0 -> ev_valid rises; drain gives ev_idx 1 then 3.
//    err[1]=0.
//  3 Spike on every slot for 2 sweeps, ev_ready=0 (8 pushes, depth 4) -> FIFO holds 0,1,2,3.
//    err[1]=1; later pops return 0,1,2,3.
//  4 Second tick issued while busy -> err[0]=1; exactly N core_start pulses occur for that sweep.
//  5 Core never asserts done for idx 2 -> after 63 WAIT cycles err[2]=1.
//    Slot 2 is unchanged and idx 3 is still issued.
//  6 Assert reset in S_WAIT of idx 1 -> next cycle busy=0, ev_valid=0, err_flags=0.
//    A new tick restarts at idx 0 with V=16'hBF00.

Source files
------------

// File: rtl/adex_pkg.sv
// Shared definitions for the AdEx scheduler slice: Q8.8 reset constants and the
// scheduler state encoding.
package adex_pkg;

  localparam int Q_FRAC = 8;
  localparam logic signed [15:0] V_INIT_Q88 = 16'(-65 <<< Q_FRAC);
  localparam logic signed [15:0] W_INIT_Q88 = 16'sd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } sched_state_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Spike-event queue: DEPTH x WIDTH, head is read straight from storage so a fresh
// push is only visible the cycle after it is written (no fall-through).
module spike_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adex_core_scheduler.sv
// Time-multiplexes one AdEx core across N_NEURONS state slots: each tick sweeps every
// slot through issue / wait / write-back and queues spiking slot indices as events.
module adex_core_scheduler
  import adex_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int STATE_W    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 63,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  output logic               core_start,
  output logic [IDX_W-1:0]   core_idx,
  output logic [STATE_W-1:0] core_v_in,
  output logic [STATE_W-1:0] core_w_in,
  input  logic               core_done,
  input  logic [STATE_W-1:0] core_v_out,
  input  logic [STATE_W-1:0] core_w_out,
  input  logic               core_spike,
  output logic               ev_valid,
  output logic [IDX_W-1:0]   ev_idx,
  input  logic               ev_ready,
  output logic               busy,
  output logic               sweep_done,
  output logic [2:0]         err_flags
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  sched_state_t       state;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [STATE_W-1:0] v_slot [N_NEURONS];
  logic [STATE_W-1:0] w_slot [N_NEURONS];
  logic [STATE_W-1:0] res_v;
  logic [STATE_W-1:0] res_w;
  logic               res_spike;
  logic               res_valid;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_drop;

  assign core_idx  = idx;
  assign core_v_in = v_slot[idx];
  assign core_w_in = w_slot[idx];

  assign fifo_push = (state == S_WB) && res_valid && res_spike;
  assign fifo_pop  = ev_valid && ev_ready;
  assign fifo_drop = fifo_push && fifo_full && !fifo_pop;
  assign ev_valid  = !fifo_empty;

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (idx),
    .pop       (fifo_pop),
    .head      (ev_idx),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      tmo_cnt    <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      err_flags  <= '0;
      res_v      <= '0;
      res_w      <= '0;
      res_spike  <= 1'b0;
      res_valid  <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_slot[i] <= STATE_W'(V_INIT_Q88);
        w_slot[i] <= STATE_W'(W_INIT_Q88);
      end
    end else begin
      core_start <= 1'b0;
      sweep_done <= 1'b0;
      // Ticks are never queued: any tick seen outside idle is an overrun.
      if (tick && state != S_IDLE) err_flags[0] <= 1'b1;
      if (fifo_drop)               err_flags[1] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick && enable) begin
            idx        <= '0;
            state      <= S_ISSUE;
            core_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_ISSUE: begin
          tmo_cnt   <= '0;
          res_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            res_v     <= core_v_out;
            res_w     <= core_w_out;
            res_spike <= core_spike;
            res_valid <= 1'b1;
            state     <= S_WB;
          end else if (tmo_cnt == TMO_LAST) begin
            err_flags[2] <= 1'b1;
            res_valid    <= 1'b0;
            state        <= S_WB;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (res_valid) begin
            v_slot[idx] <= res_v;
            w_slot[idx] <= res_w;
          end
          if (idx == LAST_IDX || !enable) begin
            sweep_done <= (idx == LAST_IDX);
            idx        <= '0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            idx        <= idx + 1'b1;
            core_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
